// File: rtl/column_pkg.sv
// column_pkg: shared constants and types for the column bank triple-buffer
package column_pkg;
  localparam int NUM_COLS = 640;
  localparam int COL_W = 28;
  localparam int CNT_W = 16;
  typedef logic [1:0] bank_idx_t;
  typedef enum logic {W_FILL, W_COMMIT} wr_state_t;
  typedef logic [COL_W-1:0] col_word_t;
  function automatic logic [2:0] bank_onehot(input bank_idx_t b);
    return 3'b001 << b;
  endfunction
endpackage

// File: rtl/bank_role_rotator.sv
// bank_role_rotator: owns the display/write/spare bank roles and the ready flag
module bank_role_rotator
  import column_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      commit,
  input  logic      flip,
  output bank_idx_t disp_bank,
  output bank_idx_t wr_bank,
  output logic      frame_ready,
  output logic      frame_flip
);
  bank_idx_t disp_q, disp_d, wr_q, wr_d, spare_q, spare_d;
  logic ready_q, ready_d, flip_q, flip_d;

  // Commit hands the finished bank to spare; flip shows spare; both at once shows the finished bank directly
  always_comb begin
    disp_d = disp_q;
    wr_d = wr_q;
    spare_d = spare_q;
    ready_d = ready_q;
    flip_d = 1'b0;
    if (commit && flip) begin
      disp_d = wr_q;
      wr_d = disp_q;
      ready_d = 1'b0;
      flip_d = 1'b1;
    end else if (commit) begin
      wr_d = spare_q;
      spare_d = wr_q;
      ready_d = 1'b1;
    end else if (flip && ready_q) begin
      disp_d = spare_q;
      spare_d = disp_q;
      ready_d = 1'b0;
      flip_d = 1'b1;
    end
  end

  // Role registers, cleared to disp=0 wr=1 spare=2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= 2'd0;
      wr_q <= 2'd1;
      spare_q <= 2'd2;
      ready_q <= 1'b0;
      flip_q <= 1'b0;
    end else begin
      disp_q <= disp_d;
      wr_q <= wr_d;
      spare_q <= spare_d;
      ready_q <= ready_d;
      flip_q <= flip_d;
    end
  end

  assign disp_bank = disp_q;
  assign wr_bank = wr_q;
  assign frame_ready = ready_q;
  assign frame_flip = flip_q;

  roles_are_permutation: assert property (@(posedge clk) disable iff (!reset)
    disp_q != wr_q && wr_q != spare_q && disp_q != spare_q &&
    disp_q != 2'd3 && wr_q != 2'd3 && spare_q != 2'd3);
endmodule

// File: rtl/column_bank_scheduler.sv
// column_bank_scheduler: routes writer columns into the write bank and triple-buffers frames to display
module column_bank_scheduler
  import column_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             col_valid,
  output logic             col_ready,
  input  logic [COL_W-1:0] col_data,
  input  logic             wr_restart,
  input  logic             vblank_start,
  output logic [2:0]       bank_we,
  output logic [9:0]       bank_addr,
  output logic [COL_W-1:0] bank_wdata,
  output logic [1:0]       disp_bank,
  output logic [1:0]       wr_bank,
  output logic             frame_ready,
  output logic             frame_flip,
  output logic [CNT_W-1:0] drop_count
);
  wr_state_t state_q, state_d;
  logic [9:0] colnum_q, colnum_d, addr_q, addr_d;
  logic [2:0] we_q, we_d;
  col_word_t wdata_q, wdata_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic ready_q, commit, xfer, last;

  assign commit = state_q == W_COMMIT;
  assign xfer = col_valid && ready_q && !wr_restart;
  assign last = colnum_q == 10'(NUM_COLS - 1);

  bank_role_rotator u_rot (
    .clk(clk),
    .reset(reset),
    .commit(commit),
    .flip(vblank_start),
    .disp_bank(disp_bank),
    .wr_bank(wr_bank),
    .frame_ready(frame_ready),
    .frame_flip(frame_flip)
  );

  // Next-state for the write FSM, column counter, bank write port and drop counter
  always_comb begin
    state_d = commit ? W_FILL : (xfer && last ? W_COMMIT : state_q);
    colnum_d = commit || wr_restart ? '0 : xfer ? (last ? '0 : colnum_q + 10'd1) : colnum_q;
    we_d = xfer ? bank_onehot(wr_bank) : 3'b000;
    addr_d = xfer ? colnum_q : addr_q;
    wdata_d = xfer ? col_data : wdata_q;
    drop_d = commit && frame_ready && !(&drop_q) ? drop_q + 1'b1 : drop_q;
  end

  // Registered write path; col_ready drops for the single commit cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= W_FILL;
      colnum_q <= '0;
      we_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      drop_q <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      colnum_q <= colnum_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      drop_q <= drop_d;
      ready_q <= state_d == W_FILL;
    end
  end

  assign col_ready = ready_q;
  assign bank_we = we_q;
  assign bank_addr = addr_q;
  assign bank_wdata = wdata_q;
  assign drop_count = drop_q;
endmodule
